// File: rtl/chacha20_keystream_scheduler.sv
// chacha20_keystream_scheduler: ChaCha20 block sequencer; define CHACHA20_KS_PREFETCH_EN for a second result buffer.
module chacha20_keystream_scheduler #(
    parameter int ENC_LATENCY = 80
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter_init,
    input  logic         key_load,
    input  logic         enable,
    output logic         enc_set_state,
    output logic [511:0] enc_round_input,
    input  logic [511:0] enc_round_output,
    output logic [511:0] ks_data,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [31:0]  block_counter,
    output logic         busy,
    output logic         counter_wrapped
);
    typedef enum logic [2:0] {UNKEYED, IDLE, SET, RUN, CAPTURE, OUT} state_t;
    state_t state;
    logic [255:0] key_q;
    logic [95:0] nonce_q;
    logic [31:0] gen_ctr;
    logic [7:0] lat;
    logic [511:0] init_state;
    logic [511:0] sum;
    logic accept;
    logic last;
    logic cap_go;
    logic start;
    logic pf_valid;
`ifdef CHACHA20_KS_PREFETCH_EN
    logic [511:0] pf_data;
    assign cap_go = enable && !last && (!ks_valid || ks_ready);
`else
    assign pf_valid = 1'b0;
    assign cap_go = 1'b0;
`endif
    assign init_state = {nonce_q, gen_ctr, key_q, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    assign accept = ks_valid && ks_ready;
    // last: the most recently started block carries counter 0xFFFFFFFF
    assign last = &enc_round_input[415:384];
    assign start = (state == IDLE && enable && !counter_wrapped) ||
                   (state == CAPTURE && cap_go) ||
                   (state == OUT && accept && enable && !last);
    for (genvar w = 0; w < 16; w++) begin : g_ff
        assign sum[32*w +: 32] = enc_round_output[32*w +: 32] + enc_round_input[32*w +: 32];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= UNKEYED;
            key_q <= '0;
            nonce_q <= '0;
            gen_ctr <= '0;
            lat <= '0;
            enc_set_state <= 1'b0;
            enc_round_input <= '0;
            ks_data <= '0;
            ks_valid <= 1'b0;
            block_counter <= '0;
            busy <= 1'b0;
            counter_wrapped <= 1'b0;
`ifdef CHACHA20_KS_PREFETCH_EN
            pf_data <= '0;
            pf_valid <= 1'b0;
`endif
        end else if (key_load) begin
            state <= IDLE;
            key_q <= key;
            nonce_q <= nonce;
            gen_ctr <= counter_init;
            block_counter <= counter_init;
            counter_wrapped <= 1'b0;
            enc_set_state <= 1'b0;
            ks_valid <= 1'b0;
            busy <= 1'b0;
`ifdef CHACHA20_KS_PREFETCH_EN
            pf_valid <= 1'b0;
`endif
        end else begin
            enc_set_state <= start;
            busy <= start || state == SET || state == RUN;
            if (start) begin
                enc_round_input <= init_state;
                gen_ctr <= gen_ctr + 32'd1;
            end
            if (accept) begin
                block_counter <= block_counter + 32'd1;
                counter_wrapped <= counter_wrapped || &block_counter;
`ifdef CHACHA20_KS_PREFETCH_EN
                if (pf_valid) begin
                    ks_data <= pf_data;
                    pf_valid <= 1'b0;
                end else begin
                    ks_valid <= 1'b0;
                end
`else
                ks_valid <= 1'b0;
`endif
            end
            case (state)
                IDLE: if (start) state <= SET;
                SET: begin
                    state <= RUN;
                    lat <= 8'd1;
                end
                RUN: if (lat == 8'(ENC_LATENCY)) state <= CAPTURE; else lat <= lat + 8'd1;
                CAPTURE: begin
                    state <= start ? SET : OUT;
`ifdef CHACHA20_KS_PREFETCH_EN
                    if (!ks_valid || ks_ready) begin
                        ks_data <= sum;
                        ks_valid <= 1'b1;
                    end else begin
                        pf_data <= sum;
                        pf_valid <= 1'b1;
                    end
`else
                    ks_data <= sum;
                    ks_valid <= 1'b1;
`endif
                end
                OUT: if (start) state <= SET; else if (accept && !pf_valid) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha20_keystream_scheduler.sv
// tb_chacha20_keystream_scheduler: directed bench with a latency-accurate ChaCha20 permutation model as the encoder.
module tb_chacha20_keystream_scheduler;
    localparam int L = 80;
`ifdef CHACHA20_KS_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic key_load = 1'b0;
    logic enable = 1'b0;
    logic ks_ready = 1'b0;
    logic [255:0] key = '0;
    logic [95:0] nonce = '0;
    logic [31:0] counter_init = '0;
    logic enc_set_state, ks_valid, busy, counter_wrapped;
    logic [511:0] enc_round_input, enc_round_output, ks_data;
    logic [31:0] block_counter;
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int set_cnt = 0;
    int acc_n = 0;
    int enc_cnt = 0;
    int acc_cyc [64];
    logic [31:0] acc_ctr [64];
    logic [511:0] pend = '0;

    chacha20_keystream_scheduler dut (
        .clock(clock), .reset(reset), .key(key), .nonce(nonce), .counter_init(counter_init),
        .key_load(key_load), .enable(enable), .enc_set_state(enc_set_state),
        .enc_round_input(enc_round_input), .enc_round_output(enc_round_output),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .block_counter(block_counter), .busy(busy), .counter_wrapped(counter_wrapped)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] perm(input logic [511:0] s);
        logic [31:0] x [16];
        logic [127:0] t;
        logic [511:0] o;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int r = 0; r < 10; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = q % 4;
                b = 4 + (q < 4 ? q : (q + 1) % 4);
                c = 8 + (q < 4 ? q : (q + 2) % 4);
                d = 12 + (q < 4 ? q : (q + 3) % 4);
                t = qr(x[a], x[b], x[c], x[d]);
                {x[d], x[c], x[b], x[a]} = t;
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
        return o;
    endfunction

    function automatic logic [31:0] wd(input logic [511:0] v, input int w);
        return v[32*w +: 32];
    endfunction

    // Encoder result only becomes valid L cycles after the start pulse
    always @(posedge clock) begin
        if (enc_set_state) begin
            pend <= perm(enc_round_input);
            enc_cnt <= 1;
        end else if (enc_cnt < 1000) begin
            enc_cnt <= enc_cnt + 1;
        end
    end
    assign enc_round_output = (enc_cnt >= L) ? pend : {16{32'hdeadbeef}};

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (enc_set_state) set_cnt <= set_cnt + 1;
        if (ks_valid && ks_ready && acc_n < 64) begin
            acc_cyc[acc_n] <= cyc;
            acc_ctr[acc_n] <= block_counter;
            acc_n <= acc_n + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [511:0] held;
        int n, sc, a0;
        repeat (3) step();
        check("rst_valid", ks_valid, 0);
        check("rst_set", enc_set_state, 0);
        check("rst_busy", busy, 0);
        check("rst_data", |ks_data, 0);
        check("rst_input", |enc_round_input, 0);
        check("rst_ctr", block_counter, 0);
        reset = 1'b0;
        enable = 1'b1;
        repeat (5) step();
        check("unkeyed_noset", set_cnt, 0);
        key = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
        nonce = 96'h00000000_4a000000_09000000;
        counter_init = 32'd1;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        check("t1_idle", {busy, enc_set_state}, 0);
        step();
        check("t2_set", enc_set_state, 1);
        check("w0", wd(enc_round_input, 0), 32'h61707865);
        check("w4", wd(enc_round_input, 4), 32'h03020100);
        check("w12", wd(enc_round_input, 12), 32'd1);
        check("w14", wd(enc_round_input, 14), 32'h4a000000);
        n = 0;
        while (!ks_valid && n < 400) begin step(); n++; end
        check("valid_lat", n, L + 2);
        check("ks_w0", wd(ks_data, 0), 32'he4e7f110);
        check("ks_w15", wd(ks_data, 15), 32'h4e3c50a2);
        held = ks_data;
        sc = set_cnt;
        repeat (50) step();
        check("hold_data", ks_data == held, 1);
        check("hold_valid", ks_valid, 1);
        check("hold_sets", set_cnt, sc + PF);
        check("hold_ctr", block_counter, 1);
        ks_ready = 1'b1;
        step();
        ks_ready = 1'b0;
        check("acc_ctr", block_counter, 2);
        check("acc_valid", ks_valid, PF);
        check("next_set", enc_set_state, 1);
        check("next_w12", wd(enc_round_input, 12), 2 + PF);
        repeat (10) step();
        check("run_busy", busy, 1);
        counter_init = 32'h100;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        check("abort_valid", ks_valid, 0);
        check("abort_busy", busy, 0);
        step();
        check("abort_set", enc_set_state, 1);
        check("abort_w12", wd(enc_round_input, 12), 32'h100);
        n = 0;
        while (!ks_valid && n < 400) begin step(); n++; end
        check("abort_lat", n, L + 2);
        counter_init = 32'd5;
        key_load = 1'b1;
        ks_ready = 1'b1;
        step();
        key_load = 1'b0;
        check("kl_hs_ctr", block_counter, 5);
        check("kl_hs_valid", ks_valid, 0);
        a0 = acc_n;
        n = 0;
        while (acc_n < a0 + 3 && n < 2000) begin step(); n++; end
        check("tp_count", acc_n >= a0 + 3, 1);
        check("tp_c0", acc_ctr[a0], 5);
        check("tp_c1", acc_ctr[a0 + 1], 6);
        check("tp_c2", acc_ctr[a0 + 2], 7);
        check("tp_gap1", acc_cyc[a0 + 1] - acc_cyc[a0], L + 3 - PF);
        check("tp_gap2", acc_cyc[a0 + 2] - acc_cyc[a0 + 1], L + 3 - PF);
        counter_init = 32'hfffffffe;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        a0 = acc_n;
        sc = set_cnt;
        n = 0;
        while (acc_n < a0 + 2 && n < 2000) begin step(); n++; end
        repeat (2 * L) step();
        check("wrap_flag", counter_wrapped, 1);
        check("wrap_ctr", block_counter, 0);
        check("wrap_blocks", acc_n - a0, 2);
        check("wrap_sets", set_cnt - sc, 2);
        check("wrap_c0", acc_ctr[a0], 32'hfffffffe);
        check("wrap_c1", acc_ctr[a0 + 1], 32'hffffffff);
        check("wrap_idle", {busy, ks_valid}, 0);
        ks_ready = 1'b0;
        counter_init = 32'd3;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        check("kl_clear", counter_wrapped, 0);
        check("kl_ctr", block_counter, 3);
        n = 0;
        while (!ks_valid && n < 400) begin step(); n++; end
        check("out_reached", ks_valid, 1);
        reset = 1'b1;
        step();
        check("rst2_flags", {ks_valid, busy, enc_set_state, counter_wrapped}, 0);
        check("rst2_ctr", block_counter, 0);
        check("rst2_data", |ks_data, 0);
        check("rst2_input", |enc_round_input, 0);
        reset = 1'b0;
        sc = set_cnt;
        repeat (20) step();
        check("rst2_noset", set_cnt, sc);
        check("rst2_idle", {busy, ks_valid}, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/chacha20_keystream_scheduler.md
# chacha20_keystream_scheduler

Sequencing controller for `chacha20_serial_encoder`. It builds the 512-bit ChaCha20 initial state from a loaded key, nonce and 32-bit block counter, then pulses the encoder's `set_state`. It waits a fixed encoder latency, applies the final word-wise feed-forward addition, and presents each 64-byte keystream block on a valid/ready interface. The block counter advances per delivered block until it wraps.

## Interface
- `ENC_LATENCY`, default 80: cycles from the `enc_set_state` pulse to a valid `enc_round_output`; legal range 1..255.
- `clock` in 1: sole clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `key` in 256: key; state word 4+i = `key[32i+31:32i]`.
- `nonce` in 96: nonce; state word 13+i = `nonce[32i+31:32i]`.
- `counter_init` in 32: initial block counter.
- `key_load` in 1: one-cycle pulse that latches `key`, `nonce` and `counter_init`.
- `enable` in 1: level; while high, blocks are generated.
- `enc_set_state` out 1: one-cycle start pulse to the encoder.
- `enc_round_input` out 512: initial state; word w is at `[32w+31:32w]`.
- `enc_round_output` in 512: encoder result (permutation only, no feed-forward).
- `ks_data` out 512: keystream block.
- `ks_valid` out 1: `ks_data` is valid.
- `ks_ready` in 1: consumer accepts the block.
- `block_counter` out 32: counter of the block currently in flight or next to start.
- `busy` out 1: high in SET, RUN or CAPTURE.
- `counter_wrapped` out 1: sticky; cleared only by `reset` or `key_load`.

## Operation
- State words: 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; 4..11 = key; 12 = counter; 13..15 = nonce.
- FSM states:
  - UNKEYED: entered at reset; `key_load` goes to IDLE.
  - IDLE: `enable`=1 and not wrapped goes to SET.
  - SET: one cycle, `enc_set_state`=1; goes to RUN.
  - RUN: a latency counter counts 1..ENC_LATENCY, then goes to CAPTURE.
  - CAPTURE: registers `ks_data[w] = enc_round_output[w] + enc_round_input[w]` mod 2^32 for every word; goes to OUT.
  - OUT: `ks_valid`=1. On `ks_ready`, the counter increments and the FSM goes to SET if `enable` and not wrapped, else to IDLE.
- `enc_round_input` is registered and held stable from SET until the next SET.
- Handshake: a block transfers on any cycle with `ks_valid` && `ks_ready`. `ks_data` is stable while `ks_valid`=1 and not accepted.
- Counter wrap: when the block with counter 0xFFFFFFFF is accepted:
  - `counter_wrapped` is set and `block_counter` becomes 0.
  - The FSM goes to IDLE and no further blocks start until `key_load`.
- `enable` falling in SET, RUN or CAPTURE: the current block completes and is delivered, then the FSM goes to IDLE.
- `key_load` in any state except UNKEYED/IDLE aborts the current block:
  - Next cycle: `ks_valid`=0, state IDLE, new key, nonce and counter latched, `counter_wrapped`=0.
  - The aborted block is never presented.
- `key_load` together with a `ks_ready` handshake: the handshake completes, `key_load` wins, and the counter takes `counter_init` (no increment).
- `key_load` in IDLE or UNKEYED: latch, then IDLE.
- Reset: state UNKEYED. All outputs are 0, including `ks_data`, `block_counter` and `enc_round_input`.

## Timing
- `key_load` at cycle t with `enable`=1 gives `enc_set_state` at t+2 (IDLE at t+1).
- SET at cycle S gives CAPTURE at S+ENC_LATENCY+1 and `ks_valid`=1 at S+ENC_LATENCY+2.
- Throughput without prefetch, with `ks_ready` held high: one block per ENC_LATENCY+3 cycles.
- `block_counter` updates on the cycle after the handshake.
- `busy` is registered, aligned with the state.

## Configuration
- `CHACHA20_KS_PREFETCH_EN` defined:
  - Adds a second 512-bit buffer. On entering OUT, the next block (counter+1) starts immediately, provided `enable`=1 and the current block is not 0xFFFFFFFF.
  - The prefetched result is held until the output register frees, then moves in on the handshake cycle. `ks_valid` stays high with no bubble.
  - Throughput with `ks_ready`=1: one block per ENC_LATENCY+2 cycles.
  - `key_load` discards both buffers.
- Not defined: a single output register only, with the behaviour above.

## Test plan
- RFC 7539 §2.3.2 vector (key 00..1f, nonce 000000090000004a00000000, `counter_init`=1, encoder model or real encoder):
  - `ks_data` word 0 = 0xe4e7f110 and word 15 = 0x4e3c50a2.
  - `ks_valid` rises exactly ENC_LATENCY+2 cycles after `enc_set_state`.
- Hold `ks_ready`=0 for 50 cycles after `ks_valid` -> `ks_data` is stable, no second `enc_set_state` (without prefetch), and `block_counter` stays 1 until accept.
- `counter_init`=0xFFFFFFFE, `enable`=1 -> two blocks delivered, then `counter_wrapped`=1, `block_counter`=0, and no third `enc_set_state` until `key_load`.
- `key_load` mid-RUN at cycle 10 -> `ks_valid` never rises for the old block, and `enc_set_state` occurs 2 cycles later with the new `counter_init` in word 12.
- `reset` asserted in OUT -> next cycle all outputs are 0 and state UNKEYED; `enable`=1 alone produces nothing.
- With `CHACHA20_KS_PREFETCH_EN` and `ks_ready`=1 -> consecutive accepts are ENC_LATENCY+2 cycles apart, with counters 5, 6, 7 in order.
